// File: rtl/snake_if.sv
// snake_if: key, scan-pixel and game-status signals between the snake controller and its host
interface snake_if;
    logic        key_up, key_down, key_left, key_right, key_start;
    logic [10:0] pixel_xpos, pixel_ypos;
    logic [9:0]  box_x, box_y;
    logic        snack_r;
    logic [7:0]  score;
    logic        game_over;
    modport master (
        output key_up, key_down, key_left, key_right, key_start, pixel_xpos, pixel_ypos,
        input  box_x, box_y, snack_r, score, game_over
    );
    modport slave (
        input  key_up, key_down, key_left, key_right, key_start, pixel_xpos, pixel_ypos,
        output box_x, box_y, snack_r, score, game_over
    );
endinterface

// File: rtl/snake_ctrl.sv
// snake_ctrl: 36x36 snake game controller with tick-paced movement, collisions, food and body pixel hit
module snake_ctrl #(
    parameter int STEP_DIV = 4_000_000,
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 3
) (
    input  logic   vga_clk,
    input  logic   sys_rst_n,
    snake_if.slave bus
);
    localparam int CW = $clog2(STEP_DIV);
    localparam int LW = $clog2(MAX_LEN + 1);
    typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;
    typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;
    state_t        state_q, state_d;
    dir_t          dir_q, dir_d, pend_q, pend_d, req;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] len_q, len_d;
    logic [7:0]    score_q, score_d;
    logic [5:0]    fx_q, fx_d, fy_q, fy_d, rx, ry, cx, cy;
    logic [5:0]    sx_q [MAX_LEN];
    logic [5:0]    sx_d [MAX_LEN];
    logic [5:0]    sy_q [MAX_LEN];
    logic [5:0]    sy_d [MAX_LEN];
    logic [15:0]   lfsr_q;
    logic [10:0]   dx, dy;
    logic [6:0]    nx, ny;
    logic          reloc_q, reloc_d, snack_q, go_q, hit, self_hit, wall, eat, tick, req_v, in_area;

    assign req_v = bus.key_up | bus.key_down | bus.key_left | bus.key_right;
    assign req   = bus.key_up ? D_UP : bus.key_down ? D_DOWN : bus.key_left ? D_LEFT : D_RIGHT;
    assign tick  = state_q == PLAY && cnt_q == CW'(STEP_DIV - 1);
    // the step uses the pending direction so a turn takes effect on the very tick that applies it
    assign nx    = {1'b0, sx_q[0]} + (pend_q == D_RIGHT ? 7'd1 : pend_q == D_LEFT ? 7'h7F : 7'd0);
    assign ny    = {1'b0, sy_q[0]} + (pend_q == D_DOWN ? 7'd1 : pend_q == D_UP ? 7'h7F : 7'd0);
    assign wall  = nx > 7'd35 || ny > 7'd35;
    assign eat   = nx[5:0] == fx_q && ny[5:0] == fy_q;
    assign rx    = lfsr_q[5:0] >= 6'd36 ? lfsr_q[5:0] - 6'd36 : lfsr_q[5:0];
    assign ry    = lfsr_q[11:6] >= 6'd36 ? lfsr_q[11:6] - 6'd36 : lfsr_q[11:6];
    assign dx    = bus.pixel_xpos - 11'd12;
    assign dy    = bus.pixel_ypos - 11'd12;
    assign cx    = 6'(dx >> 4);
    assign cy    = 6'(dy >> 4);
    assign in_area = bus.pixel_xpos >= 11'd12 && bus.pixel_xpos <= 11'd587 &&
                     bus.pixel_ypos >= 11'd12 && bus.pixel_ypos <= 11'd587 &&
                     dx[3:0] != 4'd0 && dx[3:0] != 4'hF && dy[3:0] != 4'd0 && dy[3:0] != 4'hF;

    always_comb begin
        self_hit = 1'b0;
        hit      = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            self_hit = self_hit | (i + 1 < int'(len_q) && {1'b0, sx_q[i]} == nx && {1'b0, sy_q[i]} == ny);
            hit      = hit | (i < int'(len_q) && sx_q[i] == cx && sy_q[i] == cy);
        end
        hit = hit & in_area;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        pend_d  = pend_q;
        len_d   = len_q;
        score_d = score_q;
        fx_d    = reloc_q ? rx : fx_q;
        fy_d    = reloc_q ? ry : fy_q;
        reloc_d = 1'b0;
        sx_d    = sx_q;
        sy_d    = sy_q;
        if (state_q != OVER && req_v && req != dir_t'(dir_q ^ 2'b01))
            pend_d = req;
        if (state_q == IDLE && bus.key_start) begin
            state_d = PLAY;
            cnt_d   = '0;
        end else if (state_q == OVER && bus.key_start) begin
            state_d = IDLE;
            cnt_d   = '0;
            dir_d   = D_RIGHT;
            pend_d  = D_RIGHT;
            len_d   = LW'(INIT_LEN);
            score_d = 8'd0;
            fx_d    = 6'd27;
            fy_d    = 6'd18;
            for (int i = 0; i < MAX_LEN; i++) begin
                sx_d[i] = 6'(18 - i);
                sy_d[i] = 6'd18;
            end
        end else if (state_q == PLAY) begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
            if (tick) begin
                dir_d = pend_q;
                if (wall || self_hit) begin
                    state_d = OVER;
                end else begin
                    for (int i = MAX_LEN - 1; i > 0; i--) begin
                        sx_d[i] = sx_q[i-1];
                        sy_d[i] = sy_q[i-1];
                    end
                    sx_d[0] = nx[5:0];
                    sy_d[0] = ny[5:0];
                    if (eat) begin
                        len_d   = len_q != LW'(MAX_LEN) ? len_q + LW'(1) : len_q;
                        score_d = score_q != 8'hFF ? score_q + 8'd1 : score_q;
                        reloc_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= D_RIGHT;
            pend_q  <= D_RIGHT;
            len_q   <= LW'(INIT_LEN);
            score_q <= 8'd0;
            fx_q    <= 6'd27;
            fy_q    <= 6'd18;
            reloc_q <= 1'b0;
            snack_q <= 1'b0;
            go_q    <= 1'b0;
            lfsr_q  <= 16'hACE1;
            for (int i = 0; i < MAX_LEN; i++) begin
                sx_q[i] <= 6'(18 - i);
                sy_q[i] <= 6'd18;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            pend_q  <= pend_d;
            len_q   <= len_d;
            score_q <= score_d;
            fx_q    <= fx_d;
            fy_q    <= fy_d;
            reloc_q <= reloc_d;
            snack_q <= hit;
            go_q    <= state_d == OVER;
            lfsr_q  <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
            sx_q    <= sx_d;
            sy_q    <= sy_d;
        end
    end

    // food origin is 16*f+9, which is just f with 4'b1001 appended
    assign bus.box_x     = {fx_q, 4'b1001};
    assign bus.box_y     = {fy_q, 4'b1001};
    assign bus.snack_r   = snack_q;
    assign bus.score     = score_q;
    assign bus.game_over = go_q;
endmodule
